id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of PC, operand and immediate fields.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 id_valid  input  1  decode slot holds a real instruction.
REQ-005 id_pc, id_rs1_data, id_rs2_data, id_imm  input  XLEN each  decode-stage PC, register-file read data and immediate.
REQ-006 id_rs1, id_rs2, id_rd  input  5 each  source and destination register numbers.
REQ-007 id_funct3  input  3; id_funct7b5  input  1  ALU-control qualifiers.
REQ-008 id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch  input  1 each  control-unit outputs.
REQ-009 id_aluop  input  2  control-unit ALU op class.
REQ-010 flush  input  1  taken branch resolved downstream; squash the decode-stage instruction.
REQ-011 ex_stall  input  1  execute stage cannot accept new work; hold register.
REQ-012 ex_* outputs  output  same widths as REQ-005..REQ-009  registered copies: ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_aluop.
REQ-013 ex_valid  output  1  execute register holds a real instruction.
REQ-014 id_hold  output  1  combinational; PC and IF/ID register must not advance this cycle.
REQ-015 bubble_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-016 load_use (combinational) SHALL be ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)); rs2 compared for every opcode (conservative).
REQ-017 id_hold SHALL equal (load_use | ex_stall) & ~flush.
REQ-018 Per-edge action priority SHALL be: rst > flush > ex_stall > load_use > load.
REQ-019 flush: ex_valid and all seven control outputs SHALL clear to 0; data fields unchanged; flush_cnt increments.
REQ-020 ex_stall (no flush): every ex_* output and ex_valid SHALL hold its value.
REQ-021 load_use (no flush, no ex_stall): bubble inserted -- ex_valid and control outputs clear to 0, data fields unchanged, bubble_cnt increments.
REQ-022 load: all ex_* fields capture id_* fields; ex_valid <= id_valid; each control output <= its id_ input AND id_valid.
REQ-023 Latency SHALL be one cycle from id_* to ex_*; no combinational path from id_* to ex_*.
REQ-024 A load-use bubble SHALL last exactly one cycle: after the bubble ex_mem_read=0, so load_use deasserts and the held instruction loads on the next edge.
REQ-025 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-026 Control outputs SHALL never be nonzero while ex_valid=0.

Reset
REQ-027 On a rising edge with rst=1: ex_valid, all control outputs, all data fields, bubble_cnt and flush_cnt SHALL become 0, overriding flush, ex_stall and load_use.
REQ-028 id_hold SHALL remain purely combinational; during reset it follows REQ-017 from current (reset) state, i.e. 0 unless ex_stall=1.

Verification
REQ-029 Plain flow: id_valid=1, id_pc=0x100, id_reg_write=1, id_aluop=2'b10 -> next cycle ex_pc=0x100, ex_reg_write=1, ex_aluop=2'b10, ex_valid=1, id_hold=0.
REQ-030 Load-use: ex holds load rd=5 (ex_mem_read=1); id_rs1=5 -> id_hold=1, next edge ex_valid=0, bubble_cnt=1; following edge decode instruction loads, id_hold=0.
REQ-031 x0 exemption: ex load with rd=0, id_rs1=0 -> id_hold=0, no bubble, bubble_cnt unchanged.
REQ-032 Flush vs hazard: load_use and flush both asserted -> id_hold=0, ex_valid=0 after edge, flush_cnt+1, bubble_cnt unchanged.
REQ-033 Stall hold: ex_stall=1 for 3 cycles with changing id_* -> ex_* constant, id_hold=1 throughout; release -> loads current id_*.
REQ-034 Saturation and reset: preload bubble_cnt to 16'hFFFF via repeated hazards, one more hazard -> stays 16'hFFFF; assert rst mid-stall -> all outputs 0 next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-cycle registered copy of decode outputs with load-use bubble,
// flush squash, execute-stall hold and saturating bubble/flush event counters.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            id_alu_src,
  input  logic            id_mem_to_reg,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic [1:0]      id_aluop,
  input  logic            flush,
  input  logic            ex_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_alu_src,
  output logic            ex_mem_to_reg,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic [1:0]      ex_aluop,
  output logic            id_hold,
  output logic [15:0]     bubble_cnt,
  output logic [15:0]     flush_cnt
);

  // Control bundle order: alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, aluop[1:0]
  logic [7:0]      r_ctrl;
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;
  logic [15:0]     r_bubble_cnt;
  logic [15:0]     r_flush_cnt;

  logic [7:0]      w_id_ctrl;
  logic            w_load_use;

  assign w_id_ctrl = {id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read,
                      id_mem_write, id_branch, id_aluop};

  // rs2 is compared even for opcodes that do not read it; a spurious bubble is harmless
  assign w_load_use = r_valid & r_ctrl[4] & (r_rd != 5'd0) & id_valid &
                      ((r_rd == id_rs1) | (r_rd == id_rs2));

  assign id_hold = (w_load_use | ex_stall) & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_pc         <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_funct3     <= '0;
      r_funct7b5   <= 1'b0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
    end else if (ex_stall) begin
      r_valid <= r_valid;
    end else if (w_load_use) begin
      // Clearing mem_read here is what guarantees the bubble lasts a single cycle
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (r_bubble_cnt != 16'hFFFF) r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end else begin
      r_valid    <= id_valid;
      r_ctrl     <= w_id_ctrl & {8{id_valid}};
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_funct3   <= id_funct3;
      r_funct7b5 <= id_funct7b5;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_rs1_data   = r_rs1_data;
  assign ex_rs2_data   = r_rs2_data;
  assign ex_imm        = r_imm;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_funct3     = r_funct3;
  assign ex_funct7b5   = r_funct7b5;
  assign ex_alu_src    = r_ctrl[7];
  assign ex_mem_to_reg = r_ctrl[6];
  assign ex_reg_write  = r_ctrl[5];
  assign ex_mem_read   = r_ctrl[4];
  assign ex_mem_write  = r_ctrl[3];
  assign ex_branch     = r_ctrl[2];
  assign ex_aluop      = r_ctrl[1:0];
  assign bubble_cnt    = r_bubble_cnt;
  assign flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: flow, load-use bubble, x0 exemption, flush priority,
// stall hold, counter saturation and reset override.
module tb_id_ex_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [2:0]      id_funct3;
  logic            id_funct7b5;
  logic            id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic [1:0]      id_aluop;
  logic            flush, ex_stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5;
  logic            ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [1:0]      ex_aluop;
  logic            id_hold;
  logic [15:0]     bubble_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_aluop(id_aluop), .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_aluop(ex_aluop), .id_hold(id_hold), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_funct3 = 0; id_funct7b5 = 0;
    id_alu_src = 0; id_mem_to_reg = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_branch = 0; id_aluop = 0;
  endtask

  task automatic id_load(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1);
    id_clear();
    id_valid = 1; id_pc = pc; id_rd = rd; id_rs1 = rs1;
    id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1; id_alu_src = 1;
  endtask

  initial begin
    id_clear();
    flush = 0; ex_stall = 0; rst = 1;
    // Reset while decode presents a live load
    id_load(32'h55, 5'd3, 5'd1);
    tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_memrd", ex_mem_read, 0);
    chk("rst_bcnt", bubble_cnt, 0);
    chk("rst_fcnt", flush_cnt, 0);
    chk("rst_hold", id_hold, 0);
    ex_stall = 1; #1;
    chk("rst_hold_stall", id_hold, 1);
    ex_stall = 0;
    tick();
    rst = 0;

    // Plain flow
    id_clear();
    id_valid = 1; id_pc = 32'h100; id_reg_write = 1; id_aluop = 2'b10;
    tick();
    chk("flow_pc", ex_pc, 32'h100);
    chk("flow_rw", ex_reg_write, 1);
    chk("flow_aluop", ex_aluop, 2'b10);
    chk("flow_valid", ex_valid, 1);
    chk("flow_hold", id_hold, 0);

    // Invalid slot: data captured, controls gated off
    id_valid = 0; id_pc = 32'h104;
    tick();
    chk("inv_valid", ex_valid, 0);
    chk("inv_rw", ex_reg_write, 0);
    chk("inv_pc", ex_pc, 32'h104);

    // Load-use on rs1
    id_load(32'h200, 5'd5, 5'd1);
    tick();
    chk("lu_ld_memrd", ex_mem_read, 1);
    id_clear();
    id_valid = 1; id_pc = 32'h204; id_rs1 = 5; id_rd = 6; id_reg_write = 1;
    #1;
    chk("lu_hold", id_hold, 1);
    tick();
    chk("lu_bub_valid", ex_valid, 0);
    chk("lu_bub_memrd", ex_mem_read, 0);
    chk("lu_bub_rw", ex_reg_write, 0);
    chk("lu_bub_pc", ex_pc, 32'h200);
    chk("lu_bcnt", bubble_cnt, 1);
    chk("lu_hold_off", id_hold, 0);
    tick();
    chk("lu_after_pc", ex_pc, 32'h204);
    chk("lu_after_rd", ex_rd, 6);
    chk("lu_after_valid", ex_valid, 1);
    chk("lu_after_bcnt", bubble_cnt, 1);

    // Load-use on rs2
    id_load(32'h300, 5'd7, 5'd2);
    tick();
    id_clear();
    id_valid = 1; id_pc = 32'h304; id_rs1 = 3; id_rs2 = 7; id_rd = 8;
    #1;
    chk("lu2_hold", id_hold, 1);
    tick();
    chk("lu2_bcnt", bubble_cnt, 2);
    tick();
    chk("lu2_after_pc", ex_pc, 32'h304);

    // x0 destination is never a hazard
    id_load(32'h400, 5'd0, 5'd4);
    tick();
    id_clear();
    id_valid = 1; id_pc = 32'h404; id_rs1 = 0; id_rs2 = 0; id_rd = 9;
    #1;
    chk("x0_hold", id_hold, 0);
    tick();
    chk("x0_valid", ex_valid, 1);
    chk("x0_pc", ex_pc, 32'h404);
    chk("x0_bcnt", bubble_cnt, 2);

    // Flush beats load-use
    id_load(32'h500, 5'd9, 5'd1);
    tick();
    id_clear();
    id_valid = 1; id_pc = 32'h504; id_rs1 = 9; id_reg_write = 1;
    flush = 1; #1;
    chk("fl_hold", id_hold, 0);
    tick();
    flush = 0;
    chk("fl_valid", ex_valid, 0);
    chk("fl_memrd", ex_mem_read, 0);
    chk("fl_pc", ex_pc, 32'h500);
    chk("fl_fcnt", flush_cnt, 1);
    chk("fl_bcnt", bubble_cnt, 2);

    // Stall hold with changing decode inputs
    id_clear();
    id_valid = 1; id_pc = 32'h600; id_rd = 10; id_reg_write = 1; id_funct3 = 3'd5;
    tick();
    chk("st_pre_pc", ex_pc, 32'h600);
    ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_pc = 32'h700 + 32'(4 * i); id_rd = 5'(i + 1); id_funct3 = 3'(i); id_reg_write = 0;
      #1;
      chk("st_hold", id_hold, 1);
      tick();
      chk("st_pc", ex_pc, 32'h600);
      chk("st_rd", ex_rd, 10);
      chk("st_rw", ex_reg_write, 1);
    end
    ex_stall = 0;
    id_pc = 32'h70C; id_rd = 4; id_reg_write = 1;
    tick();
    chk("st_rel_pc", ex_pc, 32'h70C);
    chk("st_rel_rd", ex_rd, 4);

    // Saturation: preload near the top, then a self-dependent load alternates load/bubble
    dut.r_bubble_cnt <= 16'hFFFD;
    dut.r_flush_cnt  <= 16'hFFFF;
    #1;
    id_load(32'h800, 5'd5, 5'd5);
    tick(); tick();
    chk("sat_b1", bubble_cnt, 16'hFFFE);
    tick(); tick();
    chk("sat_b2", bubble_cnt, 16'hFFFF);
    tick(); tick();
    chk("sat_b3", bubble_cnt, 16'hFFFF);
    flush = 1;
    tick();
    flush = 0;
    chk("sat_f", flush_cnt, 16'hFFFF);

    // Reset mid-stall overrides everything
    id_clear();
    id_valid = 1; id_pc = 32'h900; id_rd = 12; id_imm = 32'hABCD; id_mem_write = 1; id_aluop = 2'b01;
    tick();
    chk("rs_pre_mw", ex_mem_write, 1);
    ex_stall = 1;
    tick();
    rst = 1;
    tick();
    chk("rs_valid", ex_valid, 0);
    chk("rs_pc", ex_pc, 0);
    chk("rs_rd", ex_rd, 0);
    chk("rs_imm", ex_imm, 0);
    chk("rs_mw", ex_mem_write, 0);
    chk("rs_aluop", ex_aluop, 0);
    chk("rs_bcnt", bubble_cnt, 0);
    chk("rs_fcnt", flush_cnt, 0);
    chk("rs_hold_stall", id_hold, 1);
    ex_stall = 0; #1;
    chk("rs_hold", id_hold, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
